// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared elevator constants, FSM status encodings and direction type
package elevator_pkg;

  localparam int FLOORS = 8;

  localparam logic [3:0] ST_SHUTDOWN  = 4'd0;
  localparam logic [3:0] ST_LEVEL     = 4'd1;
  localparam logic [3:0] ST_UPGOING   = 4'd2;
  localparam logic [3:0] ST_DOWNGOING = 4'd3;
  localparam logic [3:0] ST_UPLEVEL   = 4'd4;
  localparam logic [3:0] ST_DOWNLEVEL = 4'd5;
  localparam logic [3:0] ST_OPENING   = 4'd6;
  localparam logic [3:0] ST_OPENED    = 4'd7;
  localparam logic [3:0] ST_CLOSING   = 4'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } dir_t;

endpackage

// File: rtl/btn_sync.sv
// rtl/btn_sync.sv - two-flop synchroniser plus rising-edge detector for raw button pins
module btn_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] raw,
  output logic [W-1:0] pulse
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;
  logic [W-1:0] prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= raw;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  // One pulse per press: a held button stays high in prev_q and cannot retrigger.
  assign pulse = sync_q & ~prev_q;

endmodule

// File: rtl/call_register.sv
// rtl/call_register.sv - latches hall and car calls, clears them as the FSM serves each floor
module call_register #(
  parameter int FLOORS = elevator_pkg::FLOORS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FLOORS-1:0] up_btn,
  input  logic [FLOORS-1:0] down_btn,
  input  logic [FLOORS-1:0] car_btn,
  input  logic              power,
  input  logic [3:0]        status,
  input  logic [2:0]        floor,
  output logic [FLOORS-1:0] upcall,
  output logic [FLOORS-1:0] downcall,
  output logic [FLOORS-1:0] floor_btn,
  output logic              pending_above,
  output logic              pending_below
);
  import elevator_pkg::*;

  logic [FLOORS-1:0] up_pulse, down_pulse, car_pulse;
  logic [FLOORS-1:0] up_nxt, down_nxt, car_nxt;
  logic [FLOORS-1:0] any_req;
  logic              above_nxt, below_nxt;
  logic              serving, shutdown;
  dir_t              dir, dir_nxt;

  btn_sync #(.W(FLOORS)) u_up_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (up_btn),
    .pulse (up_pulse)
  );

  btn_sync #(.W(FLOORS)) u_down_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (down_btn),
    .pulse (down_pulse)
  );

  btn_sync #(.W(FLOORS)) u_car_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (car_btn),
    .pulse (car_pulse)
  );

  assign serving  = (status == ST_OPENING) || (status == ST_OPENED);
  assign shutdown = !power || (status == ST_SHUTDOWN);

  always_comb begin
    dir_nxt = dir;
    case (status)
      ST_UPGOING, ST_UPLEVEL:     dir_nxt = UP;
      ST_DOWNGOING, ST_DOWNLEVEL: dir_nxt = DOWN;
      ST_LEVEL, ST_SHUTDOWN:      dir_nxt = IDLE;
      default:                    dir_nxt = dir;
    endcase
  end

  // Priority low to high: set, served clear, shutdown clear (later writes win).
  always_comb begin
    up_nxt   = upcall | up_pulse;
    down_nxt = downcall | down_pulse;
    car_nxt  = floor_btn | car_pulse;
    if (serving) begin
      car_nxt[floor] = 1'b0;
      if (dir != DOWN || floor == 3'd0)
        up_nxt[floor] = 1'b0;
      if (dir != UP || int'(floor) == FLOORS - 1)
        down_nxt[floor] = 1'b0;
    end
    up_nxt[FLOORS-1] = 1'b0;
    down_nxt[0]      = 1'b0;
    if (shutdown) begin
      up_nxt   = '0;
      down_nxt = '0;
      car_nxt  = '0;
    end
  end

  assign any_req = upcall | downcall | floor_btn;

  always_comb begin
    above_nxt = 1'b0;
    below_nxt = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (any_req[i] && i > int'(floor)) above_nxt = 1'b1;
      if (any_req[i] && i < int'(floor)) below_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir           <= IDLE;
      upcall        <= '0;
      downcall      <= '0;
      floor_btn     <= '0;
      pending_above <= 1'b0;
      pending_below <= 1'b0;
    end else begin
      dir           <= dir_nxt;
      upcall        <= up_nxt;
      downcall      <= down_nxt;
      floor_btn     <= car_nxt;
      pending_above <= above_nxt;
      pending_below <= below_nxt;
    end
  end

endmodule

// File: tb/tb_call_register.sv
// tb/tb_call_register.sv - scoreboard bench for call_register against a floor-level request model
module tb_call_register;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] up_btn, down_btn, car_btn;
  logic         power;
  logic [3:0]   status;
  logic [2:0]   floor;
  logic [N-1:0] upcall, downcall, floor_btn;
  logic         pending_above, pending_below;

  call_register #(.FLOORS(N)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .up_btn        (up_btn),
    .down_btn      (down_btn),
    .car_btn       (car_btn),
    .power         (power),
    .status        (status),
    .floor         (floor),
    .upcall        (upcall),
    .downcall      (downcall),
    .floor_btn     (floor_btn),
    .pending_above (pending_above),
    .pending_below (pending_below)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] up;
    logic [N-1:0] dn;
    logic [N-1:0] fb;
    logic         pa;
    logic         pb;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: per-floor request flags, travel direction (0 idle, 1 up, 2 down)
  // and the last three sampled levels of each raw button (age 0 newest).
  bit m_up[N], m_dn[N], m_fb[N];
  bit m_pa, m_pb;
  int m_dir;
  bit hist[3][3][N];

  function automatic exp_t snapshot();
    exp_t e;
    for (int i = 0; i < N; i++) begin
      e.up[i] = m_up[i];
      e.dn[i] = m_dn[i];
      e.fb[i] = m_fb[i];
    end
    e.pa = m_pa;
    e.pb = m_pb;
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_up[i] = 0; m_dn[i] = 0; m_fb[i] = 0;
      for (int s = 0; s < 3; s++)
        for (int a = 0; a < 3; a++) hist[s][a][i] = 0;
    end
    m_pa = 0; m_pb = 0; m_dir = 0;
  endtask

  // A press is taken on the edge where the level seen two edges ago is high
  // and the one seen three edges ago was low.
  task automatic model_edge();
    bit press[3][N];
    bit opened;
    if (rst_n) begin
      for (int i = 0; i < N; i++) begin
        for (int s = 0; s < 3; s++) begin
          press[s][i] = hist[s][1][i] && !hist[s][2][i];
          hist[s][2][i] = hist[s][1][i];
          hist[s][1][i] = hist[s][0][i];
        end
        hist[0][0][i] = up_btn[i];
        hist[1][0][i] = down_btn[i];
        hist[2][0][i] = car_btn[i];
      end
      m_pa = 0; m_pb = 0;
      for (int i = 0; i < N; i++)
        if (m_up[i] || m_dn[i] || m_fb[i]) begin
          if (i > int'(floor)) m_pa = 1;
          if (i < int'(floor)) m_pb = 1;
        end
      opened = (status == 4'd6) || (status == 4'd7);
      for (int i = 0; i < N; i++) begin
        m_up[i] = m_up[i] || press[0][i];
        m_dn[i] = m_dn[i] || press[1][i];
        m_fb[i] = m_fb[i] || press[2][i];
        if (opened && i == int'(floor)) begin
          m_fb[i] = 0;
          if (m_dir != 2 || i == 0) m_up[i] = 0;
          if (m_dir != 1 || i == N - 1) m_dn[i] = 0;
        end
        if (i == N - 1) m_up[i] = 0;
        if (i == 0) m_dn[i] = 0;
        if (!power || status == 4'd0) begin
          m_up[i] = 0; m_dn[i] = 0; m_fb[i] = 0;
        end
      end
      if (status == 4'd2 || status == 4'd4) m_dir = 1;
      else if (status == 4'd3 || status == 4'd5) m_dir = 2;
      else if (status == 4'd1 || status == 4'd0) m_dir = 0;
    end
    exp_q.push_back(snapshot());
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #2;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Drop reset between edges; the monitor's next sample must already see zeros.
  task automatic async_reset();
    #1;
    rst_n = 1'b0;
    model_reset();
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    exp_q.push_back(snapshot());
  endtask

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("upcall", upcall, e.up);
        check("downcall", downcall, e.dn);
        check("floor_btn", floor_btn, e.fb);
        check("pending_above", {{(N-1){1'b0}}, pending_above}, {{(N-1){1'b0}}, e.pa});
        check("pending_below", {{(N-1){1'b0}}, pending_below}, {{(N-1){1'b0}}, e.pb});
      end
    end
  end

  initial begin
    int v, b;
    rst_n = 1'b0; up_btn = '0; down_btn = '0; car_btn = '0;
    power = 1'b1; status = 4'd1; floor = 3'd0;
    model_reset();
    ticks(2);
    rst_n = 1'b1;
    ticks(2);

    car_btn[5] = 1'b1; ticks(4);
    car_btn[5] = 1'b0; ticks(4);

    floor = 3'd3;
    up_btn[3] = 1'b1; down_btn[3] = 1'b1; tick();
    up_btn = '0; down_btn = '0; ticks(3);
    status = 4'd2; tick(); status = 4'd4; tick(); status = 4'd6; ticks(2);
    status = 4'd8; tick(); status = 4'd1; tick();
    up_btn[3] = 1'b1; tick(); up_btn = '0; ticks(3);
    status = 4'd3; tick(); status = 4'd5; tick(); status = 4'd6; ticks(2);
    status = 4'd8; tick(); status = 4'd1; ticks(2);

    floor = 3'd2; up_btn[2] = 1'b1; ticks(4);
    status = 4'd6; tick(); status = 4'd7; tick(); status = 4'd8; tick();
    status = 4'd1; ticks(4);
    up_btn[2] = 1'b0; tick();

    floor = 3'd4; status = 4'd7;
    car_btn[4] = 1'b1; car_btn[6] = 1'b1; ticks(4);
    car_btn = '0; status = 4'd1; ticks(2);

    floor = 3'd3;
    up_btn[1] = 1'b1; down_btn[6] = 1'b1; car_btn[7] = 1'b1; ticks(4);
    up_btn = '0; down_btn = '0; car_btn = '0; ticks(2);
    power = 1'b0; tick();
    car_btn[2] = 1'b1; up_btn[5] = 1'b1; ticks(4);
    car_btn = '0; up_btn = '0; ticks(2);
    power = 1'b1; ticks(3);

    up_btn[4] = 1'b1; car_btn[1] = 1'b1; ticks(4);
    async_reset();
    up_btn = '0; car_btn = '0;
    up_btn[7] = 1'b1; down_btn[0] = 1'b1; ticks(2);
    rst_n = 1'b1; ticks(5);
    up_btn = '0; down_btn = '0; ticks(4);

    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(2) == 0) begin
        v = $urandom_range(2);
        b = $urandom_range(N - 1);
        case (v)
          0: up_btn[b] = ~up_btn[b];
          1: down_btn[b] = ~down_btn[b];
          default: car_btn[b] = ~car_btn[b];
        endcase
      end
      if ($urandom_range(5) == 0) status = 4'($urandom_range(8));
      if ($urandom_range(5) == 0) floor = 3'($urandom_range(N - 1));
      if ($urandom_range(7) == 0) power = ($urandom_range(9) != 0);
      if (c % 150 == 75) begin
        async_reset();
        tick();
        rst_n = 1'b1;
      end
      tick();
    end

    ticks(2);
    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
